stream_demux1to2: RTL and testbench

- Registered 1-to-2 stream demultiplexer; the inverse of the team's 2:1 mux.
- A single valid/ready input stream is steered by a per-beat select bit into one of two output streams.
- Each output has its own small FIFO, so one stalled output does not lose data on the other; it blocks only beats that select it.
- Sits between one producer and two consumers; every data path is registered.

---
 rtl/demux_pkg.sv | 11 +
 rtl/demux_fifo.sv | 47 ++++
 rtl/stream_demux1to2.sv | 54 +++++
 tb/tb_stream_demux1to2.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared channel encodings and pointer-width helper for the 1-to-2 stream demux
package demux_pkg;
  localparam logic CH_OUT0 = 1'b0;
  localparam logic CH_OUT1 = 1'b1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 1; i < n; i = i * 2) r++;
    return r;
  endfunction
endpackage

// File: rtl/demux_fifo.sv
// demux_fifo: registered show-ahead FIFO, one per demux output channel
module demux_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] head_data
);
  localparam int PW = clog2(DEPTH);
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]      occ_q, occ_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;
  assign full      = occ_q == (PW+1)'(DEPTH);
  assign valid     = occ_q != '0;
  assign head_data = mem_q[rd_q];
  // Pointer and occupancy next state; pushes into a full FIFO and pops from an empty one are ignored
  always_comb begin
    do_push = push & ~full;
    do_pop  = pop & valid;
    wr_d    = wr_q + PW'(do_push);
    rd_d    = rd_q + PW'(do_pop);
    occ_d   = occ_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end
  // State and storage registers; reset clears everything so the head reads zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
      if (do_push) mem_q[wr_q] <= push_data;
    end
  end
endmodule

// File: rtl/stream_demux1to2.sv
// stream_demux1to2: steers one valid/ready stream into two independently buffered outputs
module stream_demux1to2
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             s,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] out0_count,
  output logic [CNT_W-1:0] out1_count
);
  logic             full0, full1, push0, push1;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  assign in_ready   = rst_n & ~(s == CH_OUT1 ? full1 : full0);
  assign out0_count = cnt0_q;
  assign out1_count = cnt1_q;
  // Select decode and push counters; counters wrap freely
  always_comb begin
    push0  = in_valid & in_ready & (s == CH_OUT0);
    push1  = in_valid & in_ready & (s == CH_OUT1);
    cnt0_d = cnt0_q + CNT_W'(push0);
    cnt1_d = cnt1_q + CNT_W'(push1);
  end
  // Accepted-beat counters per channel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end
  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .rst_n(rst_n), .push(push0), .push_data(in_data), .pop(out0_ready),
    .full(full0), .valid(out0_valid), .head_data(out0_data)
  );
  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .rst_n(rst_n), .push(push1), .push_data(in_data), .pop(out1_ready),
    .full(full1), .valid(out1_valid), .head_data(out1_data)
  );
endmodule

// File: tb/tb_stream_demux1to2.sv
// tb_stream_demux1to2: vector table plus queue scoreboard for the 1-to-2 stream demux
module tb_stream_demux1to2;
  localparam int D = 2;
  logic       clk = 0, rst_n = 0, in_valid = 0, s = 0, out0_ready = 0, out1_ready = 0;
  logic [7:0] in_data = 0;
  logic       in_ready, out0_valid, out1_valid;
  logic [7:0] out0_data, out1_data, out0_count, out1_count;

  stream_demux1to2 #(.WIDTH(8), .DEPTH(D), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .s(s),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .out0_count(out0_count), .out1_count(out1_count)
  );

  always #5 clk = ~clk;

  int nvec = 0, nbad = 0, p0 = 0, p1 = 0;
  logic [7:0] q0[$], q1[$];
  logic [7:0] mc0 = 0, mc1 = 0;
  logic       exp_rdy, m_pop0, m_pop1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare DUT against model state, then apply this cycle's handshakes to the model
  always @(negedge clk) begin
    chk("out0_valid", {31'd0, out0_valid}, {31'd0, q0.size() != 0});
    chk("out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() != 0});
    if (q0.size() != 0) chk("out0_data", {24'd0, out0_data}, {24'd0, q0[0]});
    if (q1.size() != 0) chk("out1_data", {24'd0, out1_data}, {24'd0, q1[0]});
    chk("out0_count", {24'd0, out0_count}, {24'd0, mc0});
    chk("out1_count", {24'd0, out1_count}, {24'd0, mc1});
    exp_rdy = rst_n && ((s ? q1.size() : q0.size()) < D);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      mc0 = 0;
      mc1 = 0;
    end else begin
      m_pop0 = out0_ready && q0.size() != 0;
      m_pop1 = out1_ready && q1.size() != 0;
      if (m_pop0) begin void'(q0.pop_front()); p0++; end
      if (m_pop1) begin void'(q1.pop_front()); p1++; end
      if (in_valid && exp_rdy) begin
        if (s) begin q1.push_back(in_data); mc1++; end
        else begin q0.push_back(in_data); mc0++; end
      end
    end
  end

  typedef struct {
    logic rst_n, v, s;
    logic [7:0] d;
    logic r0, r1, er, ev0, ev1;
  } vec_t;
  vec_t tbl[29];

  task automatic drain();
    int n;
    n = 0;
    in_valid = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q0.size() + q1.size(), 0);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst_n = 0; in_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("rst out0_data", {24'd0, out0_data}, 0);
    chk("rst out1_data", {24'd0, out1_data}, 0);
  endtask

  logic [7:0] base0, base1;
  int bp0, bp1, bq1;

  initial begin
    tbl = '{
      '{1,1,0,8'h01,0,0,1,0,0}, '{1,1,0,8'h02,0,0,1,1,0}, '{1,1,0,8'h03,0,0,0,1,0},
      '{1,1,1,8'h04,0,0,1,1,0}, '{1,1,1,8'h05,0,0,1,1,1}, '{1,1,1,8'h06,0,0,0,1,1},
      '{0,1,0,8'hA5,0,0,0,1,1}, '{1,1,0,8'hA5,1,0,1,0,0}, '{1,0,0,8'h00,1,0,1,1,0},
      '{1,0,0,8'h00,1,0,1,0,0}, '{1,1,1,8'h11,0,0,1,0,0}, '{1,1,1,8'h22,0,0,1,0,1},
      '{1,1,1,8'h99,0,0,0,0,1}, '{1,1,0,8'h33,1,0,1,0,1}, '{1,0,0,8'h00,1,1,1,1,1},
      '{1,0,0,8'h00,0,1,1,0,1}, '{1,0,0,8'h00,0,0,1,0,0}, '{1,1,0,8'h40,0,0,1,0,0},
      '{1,1,0,8'h41,1,0,1,1,0}, '{1,1,0,8'h42,1,0,1,1,0}, '{1,0,0,8'h00,1,0,1,1,0},
      '{1,0,0,8'h00,0,0,1,0,0}, '{1,1,0,8'h50,0,0,1,0,0}, '{1,1,0,8'h51,0,0,1,1,0},
      '{1,1,0,8'h52,1,0,0,1,0}, '{1,1,0,8'h52,1,0,1,1,0}, '{1,0,0,8'h00,1,0,1,1,0},
      '{1,0,0,8'h00,0,0,1,0,0}, '{1,0,0,8'h00,0,0,1,0,0}
    };
    repeat (2) @(posedge clk);
    for (int i = 0; i < 29; i++) begin
      @(posedge clk); #1;
      rst_n = tbl[i].rst_n; in_valid = tbl[i].v; s = tbl[i].s; in_data = tbl[i].d;
      out0_ready = tbl[i].r0; out1_ready = tbl[i].r1;
      @(negedge clk);
      chk($sformatf("row%0d in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].er});
      chk($sformatf("row%0d out0_valid", i), {31'd0, out0_valid}, {31'd0, tbl[i].ev0});
      chk($sformatf("row%0d out1_valid", i), {31'd0, out1_valid}, {31'd0, tbl[i].ev1});
    end
    reset_pulse();
    base0 = out0_count; base1 = out1_count; bp0 = p0; bp1 = p1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      in_valid = 1; s = i[0]; in_data = 8'(i); out0_ready = 1; out1_ready = 1;
      @(negedge clk);
      chk("stream in_ready", {31'd0, in_ready}, 1);
      if (i > 0) chk("stream no bubble", {31'd0, i[0] ? out0_valid : out1_valid}, 1);
    end
    @(posedge clk); #1;
    drain();
    chk("stream out0_count", {24'd0, 8'(out0_count - base0)}, 50);
    chk("stream out1_count", {24'd0, 8'(out1_count - base1)}, 50);
    chk("stream out0 pops", p0 - bp0, 50);
    chk("stream out1 pops", p1 - bp1, 50);
    reset_pulse();
    bq1 = p1;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      in_valid = 1; s = 1; in_data = 8'(i ^ 8'h5A); out1_ready = 1; out0_ready = 0;
    end
    @(posedge clk); #1;
    drain();
    chk("wrap out1_count", {24'd0, out1_count}, 0);
    chk("wrap out0_count", {24'd0, out0_count}, 0);
    chk("wrap out1 pops", p1 - bq1, 256);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
